// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Decode-side handshake and instruction-memory bus of the fetch unit.
// master: the fetch unit; slave: decode/hazard logic plus instruction memory.
interface fetch_prefetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              i_stall;
  logic              i_redirect;
  logic [31:0]       i_redirect_pc;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_rvld;
  logic [31:0]       i_imem_rdata;
  logic              o_vld;
  logic [31:0]       o_inst;
  logic [31:0]       o_pc;

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_rvld, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_vld, o_inst, o_pc
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_rvld, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_vld, o_inst, o_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO of {pc, inst} entries with synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_push,
  input  fetch_entry_t     i_push_data,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: credit-limited sequential fetch into a prefetch
// FIFO, decode handshake on the FIFO head, redirect flush with stale-response drop.
// Optional build macro FETCH_PERF_CNT_EN adds redirect and empty-cycle counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fetch_prefetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            o_perf_redirects,
  output logic [31:0]            o_perf_empty_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_next_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_issue;
  logic             w_rsp_valid;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;

  // A response counts only if something is outstanding; stray beats are ignored.
  assign w_rsp_valid = bus.i_imem_rvld && (r_inflight != '0);
  assign w_push      = w_rsp_valid && (r_drop == '0) && !bus.i_redirect;
  assign w_pop       = !w_empty && !bus.i_stall && !bus.i_redirect;
  assign w_push_data = '{pc: r_resp_pc, inst: bus.i_imem_rdata};

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next state and request issue; redirect overrides and suppresses issue.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE:    w_next_state = FETCH;
      FETCH:   w_issue = ((SUM_W'(w_count) + SUM_W'(r_inflight)) < SUM_W'(DEPTH));
      FLUSH:   w_next_state = FETCH;
      default: w_next_state = IDLE;
    endcase
    if (bus.i_redirect) begin
      w_next_state = FLUSH;
      w_issue      = 1'b0;
    end
  end

  // Outstanding-request and pending-discard counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_rsp_valid);
      if (bus.i_redirect)                   r_drop <= r_inflight - CNT_W'(w_rsp_valid);
      else if (w_rsp_valid && r_drop != '0) r_drop <= r_drop - CNT_W'(1);
    end
  end

  // Request PC and the PC owed to the next kept response (responses are in order).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (bus.i_redirect) begin
      r_fetch_pc <= word_align(bus.i_redirect_pc);
      r_resp_pc  <= word_align(bus.i_redirect_pc);
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)  r_resp_pc  <= r_resp_pc + 32'd4;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clr       (bus.i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign bus.o_imem_req  = w_issue;
  assign bus.o_imem_addr = r_fetch_pc[ADDR_W-1:0];
  assign bus.o_vld       = !w_empty;
  assign bus.o_inst      = w_empty ? NOP_INST : w_head.inst;
  assign bus.o_pc        = w_empty ? 32'h0 : w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  // Saturating counts of redirects and of starved FETCH cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_redirects    <= '0;
      o_perf_empty_cycles <= '0;
    end else begin
      if (bus.i_redirect && o_perf_redirects != '1)
        o_perf_redirects <= o_perf_redirects + 32'd1;
      if (r_state == FETCH && w_empty && o_perf_empty_cycles != '1)
        o_perf_empty_cycles <= o_perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an instruction-memory model and
// a {pc, inst} scoreboard. Build with FETCH_PERF_CNT_EN to cover the counters.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          epoch;
    int unsigned due;
  } mreq_t;

  typedef enum int {M_IDLE, M_FETCH, M_FLUSH} mstate_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redir;
  logic [31:0] perf_empty;
`endif

  fetch_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .ADDR_W   (ADDR_W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_redirects    (perf_redir),
    .o_perf_empty_cycles (perf_empty)
`endif
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  int unsigned  cyc      = 0;
  int unsigned  lat      = 1;
  int           epoch    = 0;
  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_addr = 32'h0;
  logic         mdl_rvld = 1'b0;
  logic [31:0]  mdl_rdata = 32'h0;
  logic [31:0]  mdl_addr = 32'h0;
  int           mdl_epoch = 0;
  logic         man_rvld = 1'b0;
  mstate_e      mst = M_IDLE;
  logic [31:0]  redir_cnt = 32'h0;
  logic [31:0]  empty_cnt = 32'h0;

  assign bus.i_imem_rvld  = mdl_rvld | man_rvld;
  assign bus.i_imem_rdata = mdl_rdata;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model (drives responses after posedge) and output monitor (at negedge).
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    mdl_rvld = 1'b0;
    if (rst) mem_q.delete();
    else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      mdl_rvld  = 1'b1;
      mdl_rdata = mem_q[0].data;
      mdl_addr  = mem_q[0].pc;
      mdl_epoch = mem_q[0].epoch;
      void'(mem_q.pop_front());
    end
    @(negedge clk);
    if (rst) begin
      chk("rst_vld", 32'(bus.o_vld), 32'h0);
      chk("rst_req", 32'(bus.o_imem_req), 32'h0);
      exp_q.delete();
      mem_q.delete();
      epoch++;
      exp_addr  = 32'h0;
      mst       = M_IDLE;
      redir_cnt = 32'h0;
      empty_cnt = 32'h0;
    end else begin
      automatic logic was_empty = (exp_q.size() == 0);
      chk("vld", 32'(bus.o_vld), 32'(!was_empty));
      if (!was_empty) begin
        chk("head_pc", bus.o_pc, exp_q[0].pc);
        chk("head_inst", bus.o_inst, exp_q[0].inst);
        if (!bus.i_stall && !bus.i_redirect) void'(exp_q.pop_front());
      end else begin
        chk("idle_inst", bus.o_inst, NOP_INST);
        chk("idle_pc", bus.o_pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirects", perf_redir, redir_cnt);
      chk("perf_empty", perf_empty, empty_cnt);
`endif
      if (mst == M_FETCH && was_empty) empty_cnt = empty_cnt + 32'd1;
      if (bus.i_redirect) redir_cnt = redir_cnt + 32'd1;
      mst = bus.i_redirect ? M_FLUSH : M_FETCH;
      if (bus.o_imem_req) begin
        chk("req_addr", 32'(bus.o_imem_addr), 32'(exp_addr[ADDR_W-1:0]));
        mem_q.push_back('{pc: exp_addr, data: mem_word(bus.o_imem_addr),
                          epoch: epoch, due: cyc + lat});
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.i_redirect) begin
        exp_q.delete();
        epoch++;
        exp_addr = word_align(bus.i_redirect_pc);
      end else if (mdl_rvld && mdl_epoch == epoch) begin
        exp_q.push_back('{pc: mdl_addr, inst: mdl_rdata});
      end
    end
  end

  initial begin
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // 1: reset release, latency 1, streaming
    tick();
    chk("t1_req", 32'(bus.o_imem_req), 32'h1);
    chk("t1_addr0", 32'(bus.o_imem_addr), 32'h0);
    chk("t1_vld_c1", 32'(bus.o_vld), 32'h0);
    tick();
    chk("t1_vld_c2", 32'(bus.o_vld), 32'h0);
    chk("t1_addr1", 32'(bus.o_imem_addr), 32'h4);
    tick();
    chk("t1_vld_c3", 32'(bus.o_vld), 32'h1);
    chk("t1_pc0", bus.o_pc, 32'h0);
    chk("t1_inst0", bus.o_inst, mem_word(16'h0));
    repeat (8) begin
      tick();
      chk("t1_stream_vld", 32'(bus.o_vld), 32'h1);
    end

    // 2: stall fills the FIFO and throttles requests
    bus.i_stall = 1'b1;
    repeat (10) tick();
    chk("t2_req_off", 32'(bus.o_imem_req), 32'h0);
    chk("t2_fill", 32'(exp_q.size()), 32'(DEPTH));
    chk("t2_vld", 32'(bus.o_vld), 32'h1);
    bus.i_stall = 1'b0;
    repeat (12) tick();

    // 3: redirect to 0x103 with two requests outstanding
    lat = 2;
    repeat (6) tick();
    for (int k = 0; k < 20; k++) begin
      if (mem_q.size() + (mdl_rvld ? 1 : 0) >= 2) break;
      tick();
    end
    chk("t3_two_inflight", 32'(mem_q.size() + (mdl_rvld ? 1 : 0) >= 2), 32'h1);
    bus.i_redirect_pc = 32'h0000_0103;
    bus.i_redirect    = 1'b1;
    tick();
    bus.i_redirect = 1'b0;
    chk("t3_vld_flush", 32'(bus.o_vld), 32'h0);
    for (int k = 0; k < 30 && !bus.o_vld; k++) tick();
    chk("t3_first_pc", bus.o_pc, 32'h100);
    tick();
    for (int k = 0; k < 30 && !bus.o_vld; k++) tick();
    chk("t3_second_pc", bus.o_pc, 32'h104);
    repeat (8) tick();

    // 4: redirect coinciding with a response while stalled
    lat = 1;
    repeat (6) tick();
    for (int k = 0; k < 20 && !mdl_rvld; k++) tick();
    bus.i_stall       = 1'b1;
    bus.i_redirect_pc = 32'h0000_2000;
    bus.i_redirect    = 1'b1;
    tick();
    bus.i_redirect = 1'b0;
    chk("t4_vld_empty", 32'(bus.o_vld), 32'h0);
    chk("t4_no_req_flush", 32'(bus.o_imem_req), 32'h0);
    tick();
    chk("t4_restart_req", 32'(bus.o_imem_req), 32'h1);
    chk("t4_restart_addr", 32'(bus.o_imem_addr), 32'h2000);
    bus.i_stall = 1'b0;
    repeat (10) tick();

    // 6: third redirect for the performance counters
    bus.i_redirect_pc = 32'h0000_0040;
    bus.i_redirect    = 1'b1;
    tick();
    bus.i_redirect = 1'b0;
    repeat (8) tick();
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_redirects", perf_redir, 32'd3);
`endif

    // 5: async reset mid-cycle, then a stray response after release
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("t5_vld", 32'(bus.o_vld), 32'h0);
    chk("t5_inst", bus.o_inst, NOP_INST);
    chk("t5_pc", bus.o_pc, 32'h0);
    chk("t5_req", 32'(bus.o_imem_req), 32'h0);
    repeat (2) tick();
    rst      = 1'b0;
    man_rvld = 1'b1;
    tick();
    man_rvld = 1'b0;
    chk("t5_no_stray", 32'(bus.o_vld), 32'h0);
    for (int k = 0; k < 10 && !bus.o_vld; k++) tick();
    chk("t5_first_pc", bus.o_pc, 32'h0);
    chk("t5_first_inst", bus.o_inst, mem_word(16'h0));
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
